// File: rtl/ping_pong_ctrl.sv
// Two-bank ping-pong buffer controller: frames the SOP-delimited input into alternating banks and
// streams each completed bank back out. Define PP_DROP_ON_FULL_EN to drop frames instead of stalling.
module ping_pong_ctrl #(
    parameter int dw           = 56,
    parameter int buffer_depth = 1440,
    parameter int Add_width    = $clog2(buffer_depth)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic                 in_sop,
    input  logic [dw-1:0]        in_data,
    output logic                 in_ready,
    output logic                 wr_select_line,
    output logic [Add_width-1:0] wr_address,
    output logic [dw-1:0]        wr_data,
    output logic                 wr_en,
    output logic                 rd_select_line,
    output logic                 rd_en,
    input  logic [dw-1:0]        rd_data_in,
    output logic                 out_valid,
    output logic [dw-1:0]        out_data,
    output logic                 out_sop,
    output logic                 out_eop,
    input  logic                 out_ready,
`ifdef PP_DROP_ON_FULL_EN
    output logic                 drop_pulse,
`endif
    output logic                 sop_err
);

`ifdef PP_DROP_ON_FULL_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif
    localparam logic [Add_width-1:0] LAST = Add_width'(buffer_depth - 1);

    typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_READ, R_DRAIN} rstate_t;

    wstate_t              wstate_q, wstate_d;
    rstate_t              rstate_q, rstate_d;
    logic                 live_q;
    logic                 wr_sel_q, wr_sel_d, rd_sel_q, rd_sel_d;
    logic [Add_width-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
    logic [1:0]           bank_full_q, bank_full_d;
    logic                 set_full, clr_full, drop_c;
    logic                 rd_pend_q, rd_sop_q, rd_eop_q;
    logic [1:0][dw-1:0]   f_data_q;
    logic [1:0]           f_sop_q, f_eop_q;
    logic                 f_wp_q, f_rp_q;
    logic [1:0]           f_cnt_q, occ;
    logic                 pop;

    // Write side: strobes are combinational from the accepted beat.
    always_comb begin
        wstate_d   = wstate_q;
        wr_sel_d   = wr_sel_q;
        wr_cnt_d   = wr_cnt_q;
        set_full   = 1'b0;
        in_ready   = 1'b0;
        wr_en      = 1'b0;
        wr_address = '0;
        sop_err    = 1'b0;
        drop_c     = 1'b0;
        case (wstate_q)
            W_IDLE: begin
                in_ready = live_q & (DROP_EN | ~bank_full_q[wr_sel_q]);
                if (in_valid && in_ready && in_sop) begin
                    wr_cnt_d = Add_width'(1);
                    if (DROP_EN && bank_full_q[wr_sel_q]) begin
                        drop_c   = 1'b1;
                        wstate_d = W_DROP;
                    end else begin
                        wr_en    = 1'b1;
                        wstate_d = W_FILL;
                    end
                end
            end
            W_FILL: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    wr_en = 1'b1;
                    if (in_sop) begin
                        // Early SOP restarts the frame in place on the same bank.
                        sop_err  = 1'b1;
                        wr_cnt_d = Add_width'(1);
                    end else begin
                        wr_address = wr_cnt_q;
                        if (wr_cnt_q == LAST) begin
                            set_full = 1'b1;
                            wr_sel_d = ~wr_sel_q;
                            wr_cnt_d = '0;
                            wstate_d = W_IDLE;
                        end else begin
                            wr_cnt_d = wr_cnt_q + 1'b1;
                        end
                    end
                end
            end
            default: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (wr_cnt_q == LAST) begin
                        wr_cnt_d = '0;
                        wstate_d = W_IDLE;
                    end else begin
                        wr_cnt_d = wr_cnt_q + 1'b1;
                    end
                end
            end
        endcase
    end

    assign wr_data        = wr_en ? in_data : '0;
    assign wr_select_line = wr_sel_q;
`ifdef PP_DROP_ON_FULL_EN
    assign drop_pulse     = drop_c;
`endif

    assign out_valid = (f_cnt_q != 2'd0);
    assign pop       = out_valid & out_ready;
    // Credit counts this cycle's pop so the skid sustains one word per clock.
    assign occ       = f_cnt_q + {1'b0, rd_pend_q} - {1'b0, pop};
    assign out_data  = f_data_q[f_rp_q];
    assign out_sop   = out_valid & f_sop_q[f_rp_q];
    assign out_eop   = out_valid & f_eop_q[f_rp_q];

    always_comb begin
        rstate_d = rstate_q;
        rd_sel_d = rd_sel_q;
        rd_cnt_d = rd_cnt_q;
        rd_en    = 1'b0;
        clr_full = 1'b0;
        case (rstate_q)
            R_IDLE: if (bank_full_q[rd_sel_q]) begin
                rd_cnt_d = '0;
                rstate_d = R_READ;
            end
            R_READ: if (occ < 2'd2) begin
                rd_en = 1'b1;
                if (rd_cnt_q == LAST) begin
                    rd_cnt_d = '0;
                    rstate_d = R_DRAIN;
                end else begin
                    rd_cnt_d = rd_cnt_q + 1'b1;
                end
            end
            default: if (pop && out_eop) begin
                clr_full = 1'b1;
                rd_sel_d = ~rd_sel_q;
                rstate_d = R_IDLE;
            end
        endcase
    end

    assign rd_select_line = rd_sel_q;

    always_comb begin
        bank_full_d = bank_full_q;
        if (clr_full) bank_full_d[rd_sel_q] = 1'b0;
        if (set_full) bank_full_d[wr_sel_q] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_q      <= 1'b0;
            wstate_q    <= W_IDLE;
            rstate_q    <= R_IDLE;
            wr_sel_q    <= 1'b0;
            rd_sel_q    <= 1'b0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            bank_full_q <= 2'b00;
            rd_pend_q   <= 1'b0;
            rd_sop_q    <= 1'b0;
            rd_eop_q    <= 1'b0;
            f_data_q    <= '0;
            f_sop_q     <= '0;
            f_eop_q     <= '0;
            f_wp_q      <= 1'b0;
            f_rp_q      <= 1'b0;
            f_cnt_q     <= '0;
        end else begin
            live_q      <= 1'b1;
            wstate_q    <= wstate_d;
            rstate_q    <= rstate_d;
            wr_sel_q    <= wr_sel_d;
            rd_sel_q    <= rd_sel_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            bank_full_q <= bank_full_d;
            rd_pend_q   <= rd_en;
            rd_sop_q    <= rd_en & (rd_cnt_q == '0);
            rd_eop_q    <= rd_en & (rd_cnt_q == LAST);
            if (rd_pend_q) begin
                f_data_q[f_wp_q] <= rd_data_in;
                f_sop_q[f_wp_q]  <= rd_sop_q;
                f_eop_q[f_wp_q]  <= rd_eop_q;
                f_wp_q           <= ~f_wp_q;
            end
            if (pop) f_rp_q <= ~f_rp_q;
            f_cnt_q <= f_cnt_q + {1'b0, rd_pend_q} - {1'b0, pop};
        end
    end

endmodule
